// File: rtl/image_parallel_processing_onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip RAM.
// Commands are accepted combinationally in the same cycle they are presented.
// Read data returns exactly one cycle later to the master that issued the read.
// Addresses at or beyond DEPTH are accepted but never reach the RAM.
// Reads to those addresses return zero, and the sticky err_range flag is set.
module image_parallel_processing_onchip_mem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 10000,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [3:0]        m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [3:0]        m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1,
  output logic              err_range
);

  // One extra bit so that DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_any_gnt;
  logic              w_is_wr;
  logic              w_in_range;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [CNT_W-1:0]  w_cnt [2];

  logic              r_last_m1;   // 1 = master 1 was granted most recently
  logic              r_rd_pend;
  logic              r_rd_owner;
  logic              r_rd_zero;   // pending read was out of range: return 0
  logic              r_err;

  // A simultaneous read and write request is treated as a write.
  assign w_req[0] = m0_read | m0_write;
  assign w_req[1] = m1_read | m1_write;

  // Round robin: on a tie the master that did not win last time is granted.
  // Nothing is granted while reset is held.
  assign w_gnt[0]  = ~reset & w_req[0] & (~w_req[1] | r_last_m1);
  assign w_gnt[1]  = ~reset & w_req[1] & (~w_req[0] | ~r_last_m1);
  assign w_any_gnt = |w_gnt;

  assign m0_waitrequest = reset | (w_req[0] & ~w_gnt[0]);
  assign m1_waitrequest = reset | (w_req[1] & ~w_gnt[1]);

  // Route the granted master's command onto the RAM port.
  always_comb begin
    w_addr  = '0;
    w_be    = '0;
    w_wdata = '0;
    w_is_wr = 1'b0;
    if (w_gnt[1]) begin
      w_addr  = m1_address;
      w_be    = m1_byteenable;
      w_wdata = m1_writedata;
      w_is_wr = m1_write;
    end else if (w_gnt[0]) begin
      w_addr  = m0_address;
      w_be    = m0_byteenable;
      w_wdata = m0_writedata;
      w_is_wr = m0_write;
    end
  end

  assign w_in_range     = ({1'b0, w_addr} < DEPTH_L);
  assign mem_address    = w_addr;
  assign mem_byteenable = w_be;
  assign mem_writedata  = w_wdata;
  assign mem_chipselect = w_any_gnt & w_in_range;
  assign mem_write      = w_any_gnt & w_in_range & w_is_wr;
  assign mem_clken      = 1'b1;

  // Track the outstanding read and the round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_pend  <= 1'b0;
      r_rd_owner <= 1'b0;
      r_rd_zero  <= 1'b0;
      r_last_m1  <= 1'b1;
    end else begin
      r_rd_pend <= w_any_gnt & ~w_is_wr;
      if (w_any_gnt & ~w_is_wr) begin
        r_rd_owner <= w_gnt[1];
        r_rd_zero  <= ~w_in_range;
      end
      if (w_any_gnt) begin
        r_last_m1 <= w_gnt[1];
      end
    end
  end

  // Sticky out-of-range flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_any_gnt & ~w_in_range) begin
      r_err <= 1'b1;
    end
  end

  assign err_range = r_err;

  // The valid strobe is masked during reset, so a read that was accepted just
  // before reset never completes.
  assign m0_readdatavalid = ~reset & r_rd_pend & ~r_rd_owner;
  assign m1_readdatavalid = ~reset & r_rd_pend & r_rd_owner;
  assign m0_readdata = (m0_readdatavalid & ~r_rd_zero) ? mem_readdata : '0;
  assign m1_readdata = (m1_readdatavalid & ~r_rd_zero) ? mem_readdata : '0;

  // Saturating per-master grant counters. Clear wins over increment.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;

    // Count accepted commands, holding at all-ones.
    always_ff @(posedge clk) begin
      if (reset || cnt_clear) begin
        r_cnt <= '0;
      end else if (w_gnt[gi] && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_cnt[gi] = r_cnt;
  end

  assign gnt_cnt0 = w_cnt[0];
  assign gnt_cnt1 = w_cnt[1];

endmodule

// File: tb/tb_image_parallel_processing_onchip_mem_arbiter.sv
// Bench for the two-master on-chip memory arbiter.
// A small RAM model sits on the mem_* port.
// A transaction-level reference model tracks four things:
//   - which master wins,
//   - what each read returns,
//   - the grant counters,
//   - the range flag.
module tb_image_parallel_processing_onchip_mem_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 10000;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] m0_address, m1_address;
  logic [3:0]        m0_byteenable, m1_byteenable;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata = '0;
  logic              cnt_clear;
  logic [CNT_W-1:0]  gnt_cnt0, gnt_cnt1;
  logic              err_range;

  image_parallel_processing_onchip_mem_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
    .cnt_clear(cnt_clear), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .err_range(err_range)
  );

  always #5 clk = ~clk;

  // Single-port RAM with a one-cycle registered read.
  logic [DATA_W-1:0] ram [1 << ADDR_W] = '{default: '0};
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  // Reference model state.
  logic [DATA_W-1:0] model_mem [1 << ADDR_W];
  int                m_last;          // master granted most recently
  bit                m_pend;
  int                m_owner;
  logic [DATA_W-1:0] m_pdata;
  int                m_cnt [2];
  bit                m_err;
  int                n_chk = 0;
  int                n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs, then advance the model.
  task automatic cyc(input bit rst, input bit clr,
                     input bit r0, input bit w0, input int a0, input logic [3:0] be0,
                     input logic [31:0] d0,
                     input bit r1, input bit w1, input int a1, input logic [3:0] be1,
                     input logic [31:0] d1);
    int g;
    int ga;
    logic [3:0] gbe;
    logic [31:0] gd;
    bit gw, inr, q0, q1, v0, v1, cs;
    reset = rst; cnt_clear = clr;
    m0_read = r0; m0_write = w0; m0_address = ADDR_W'(a0); m0_byteenable = be0; m0_writedata = d0;
    m1_read = r1; m1_write = w1; m1_address = ADDR_W'(a1); m1_byteenable = be1; m1_writedata = d1;
    @(negedge clk);
    q0 = r0 | w0;
    q1 = r1 | w1;
    g = -1;
    if (!rst) begin
      if (q0 && q1) g = 1 - m_last;
      else if (q0) g = 0;
      else if (q1) g = 1;
    end
    ga = (g == 1) ? a1 : a0;
    gbe = (g == 1) ? be1 : be0;
    gd = (g == 1) ? d1 : d0;
    gw = (g == 1) ? w1 : w0;
    inr = ga < DEPTH;
    cs = (g >= 0) && inr;
    v0 = !rst && m_pend && m_owner == 0;
    v1 = !rst && m_pend && m_owner == 1;
    chk("m0_waitrequest", m0_waitrequest, rst ? 1 : (q0 && g != 0));
    chk("m1_waitrequest", m1_waitrequest, rst ? 1 : (q1 && g != 1));
    chk("mem_chipselect", mem_chipselect, cs);
    chk("mem_write", mem_write, cs && gw);
    if (cs) begin
      chk("mem_address", mem_address, ga);
      chk("mem_byteenable", mem_byteenable, gbe);
      if (gw) chk("mem_writedata", mem_writedata, gd);
    end
    chk("m0_readdatavalid", m0_readdatavalid, v0);
    chk("m1_readdatavalid", m1_readdatavalid, v1);
    chk("m0_readdata", m0_readdata, v0 ? m_pdata : 0);
    chk("m1_readdata", m1_readdata, v1 ? m_pdata : 0);
    chk("gnt_cnt0", gnt_cnt0, m_cnt[0]);
    chk("gnt_cnt1", gnt_cnt1, m_cnt[1]);
    chk("err_range", err_range, m_err);
    chk("mem_clken", mem_clken, 1);
    if (rst) $display("t=%0t reset", $time);
    else if (g >= 0) $display("t=%0t m%0d %s addr=%0d", $time, g, gw ? "WR" : "RD", ga);
    // Advance the model to the state after this clock edge.
    if (rst) begin
      m_last = 1; m_pend = 0; m_cnt[0] = 0; m_cnt[1] = 0; m_err = 0;
    end else begin
      m_pend = 0;
      if (g >= 0) begin
        m_last = g;
        if (!inr) m_err = 1;
        if (gw) begin
          if (inr)
            for (int b = 0; b < 4; b++)
              if (gbe[b]) model_mem[ga][8*b +: 8] = gd[8*b +: 8];
        end else begin
          m_pend = 1; m_owner = g;
          m_pdata = inr ? model_mem[ga] : '0;
        end
      end
      if (clr) begin
        m_cnt[0] = 0; m_cnt[1] = 0;
      end else if (g >= 0 && m_cnt[g] < CMAX) begin
        m_cnt[g]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rst);
    cyc(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int ra0, ra1;
    for (int i = 0; i < (1 << ADDR_W); i++) model_mem[i] = '0;
    m_last = 1; m_pend = 0; m_owner = 0; m_pdata = '0;
    m_cnt[0] = 0; m_cnt[1] = 0; m_err = 0;
    @(posedge clk); #1;
    // Reset, with requests pending on the second cycle.
    idle(1);
    cyc(1, 0, 1, 0, 3, 4'hF, 0, 0, 1, 4, 4'hF, 32'h1);
    idle(0);
    // Single write, then read back on m0.
    cyc(0, 0, 0, 1, 5, 4'hF, 32'hA5A5_1234, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 5, 4'hF, 0, 0, 0, 0, 0, 0);
    idle(0);
    // Contention: both masters reading for four cycles.
    repeat (4) cyc(0, 0, 1, 0, 1, 4'hF, 0, 1, 0, 2, 4'hF, 0);
    idle(0);
    // Back-to-back reads by m1, after distinct fills including a partial write.
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, i, 4'hF, 32'h1111_0000 * (i + 1) + i);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 4'b0101, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, i, 4'hF, 0);
    idle(0);
    // Out-of-range write then read.
    cyc(0, 0, 0, 1, 10000, 4'hF, 32'h5555_AAAA, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 10001, 4'hF, 0, 0, 0, 0, 0, 0);
    idle(0); idle(0);
    // Reset in the cycle after a read accept, then a tie.
    cyc(0, 0, 1, 0, 5, 4'hF, 0, 0, 0, 0, 0, 0);
    idle(1);
    cyc(0, 0, 1, 0, 1, 4'hF, 0, 1, 0, 2, 4'hF, 0);
    idle(0);
    // Counter saturation, then a clear that coincides with an accept.
    repeat (CMAX + 2) cyc(0, 0, 0, 1, 7, 4'hF, $urandom, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 7, 4'hF, 0, 0, 0, 0, 0, 0);
    idle(0);
    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      ra0 = ($urandom_range(0, 15) == 0) ? $urandom_range(DEPTH - 2, DEPTH + 2) : $urandom_range(0, 15);
      ra1 = ($urandom_range(0, 15) == 0) ? $urandom_range(DEPTH - 2, DEPTH + 2) : $urandom_range(0, 15);
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0,
          1'($urandom), 1'($urandom), ra0, 4'($urandom), $urandom,
          1'($urandom), 1'($urandom), ra1, 4'($urandom), $urandom);
    end
    idle(0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
